// File: rtl/rca_cfg_decoder.sv
// RCA configuration instruction executor: buffers config instructions, range-checks
// their fields, drives one config-write strobe each and returns an ok/error completion.
module rca_cfg_decoder #(
  parameter int NUM_RCAS        = 4,
  parameter int NUM_GRID_MUXES  = 72,
  parameter int NUM_IO_MUXES    = 6,
  parameter int NUM_WRITE_PORTS = 5,
  parameter int NUM_READ_PORTS  = 5,
  parameter int FIFO_DEPTH      = 2,
  parameter int ID_W            = 3,
  localparam int RCA_W          = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [2:0]       issue_funct3,
  input  logic [6:0]       issue_funct7,
  input  logic [31:0]      issue_rs1,
  input  logic [31:0]      issue_rs2,
  input  logic [ID_W-1:0]  issue_id,
  output logic             cfg_we,
  output logic [2:0]       cfg_type,
  output logic [RCA_W-1:0] cfg_rca,
  output logic [6:0]       cfg_index,
  output logic [7:0]       cfg_data,
  output logic             wb_valid,
  input  logic             wb_ack,
  output logic [ID_W-1:0]  wb_id,
  output logic             wb_err,
  output logic             cfg_pending
);

  localparam int PTR_W           = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W           = PTR_W + 1;
  localparam int GRID_MUX_INPUTS = 8;
  localparam int IO_MUX_INPUTS   = 11;
  localparam int GRID_NUM_COLS   = NUM_IO_MUXES;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_APPLY = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  typedef struct packed {
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [31:0]     rs1;
    logic [31:0]     rs2;
    logic [ID_W-1:0] id;
  } entry_t;

  entry_t            mem_r [FIFO_DEPTH];
  entry_t            inst_r;
  entry_t            head_s;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [1:0]        state_r;
  logic              push_s;
  logic              pop_s;
  logic              err_s;
  logic [6:0]        index_s;
  logic [7:0]        data_s;

  // Full 32-bit operands are compared so stray upper bits also flag an error.
  function automatic logic check_err(input logic [2:0] f3, input logic [6:0] f7,
                                     input logic [31:0] rs1, input logic [31:0] rs2);
    logic rca_bad;
    logic err;
    rca_bad = ({25'd0, f7} >= NUM_RCAS);
    case (f3)
      3'b001:  err = rca_bad || (rs1 >= 32'd32) || (rs2 >= 32'd32) ||
                     ({29'd0, rs1[2:0]} >= (rs1[3] ? NUM_WRITE_PORTS : NUM_READ_PORTS));
      3'b010:  err = (rs1 >= NUM_GRID_MUXES) || (rs2 >= GRID_MUX_INPUTS);
      3'b011:  err = (rs1 >= NUM_IO_MUXES) || (rs2 >= IO_MUX_INPUTS);
      3'b100:  err = rca_bad || (rs1 >= NUM_WRITE_PORTS) || (rs2 >= GRID_NUM_COLS);
      3'b101:  err = rca_bad || (rs1 >= (32'd1 << NUM_READ_PORTS));
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  assign head_s      = mem_r[rd_ptr_r];
  assign issue_ready = (count_r != CNT_W'(FIFO_DEPTH));
  assign cfg_pending = (count_r != {CNT_W{1'b0}}) || (state_r != ST_IDLE);
  assign push_s      = issue_valid && issue_ready;
  assign pop_s       = (count_r != {CNT_W{1'b0}}) &&
                       ((state_r == ST_IDLE) || ((state_r == ST_RESP) && wb_ack));

  // Instruction FIFO storage, pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= {$bits(entry_t){1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= '{f3: issue_funct3, f7: issue_funct7, rs1: issue_rs1,
                             rs2: issue_rs2, id: issue_id};
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Field extraction of the instruction currently being applied
  always_comb begin
    err_s   = check_err(inst_r.f3, inst_r.f7, inst_r.rs1, inst_r.rs2);
    index_s = 7'd0;
    data_s  = 8'd0;
    case (inst_r.f3)
      3'b001: begin
        index_s = {2'b00, inst_r.rs1[4:0]};
        data_s  = {3'b000, inst_r.rs2[4:0]};
      end
      3'b010, 3'b100: begin
        index_s = inst_r.rs1[6:0];
        data_s  = {5'b00000, inst_r.rs2[2:0]};
      end
      3'b011: begin
        index_s = inst_r.rs1[6:0];
        data_s  = {4'b0000, inst_r.rs2[3:0]};
      end
      3'b101: begin
        index_s = 7'd0;
        data_s  = 8'(inst_r.rs1[NUM_READ_PORTS-1:0]);
      end
      default: begin
        index_s = 7'd0;
        data_s  = 8'd0;
      end
    endcase
  end

  // Sequencer: IDLE pops the head, APPLY registers the write, RESP waits for wb_ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      inst_r  <= {$bits(entry_t){1'b0}};
    end else begin
      if (pop_s) inst_r <= head_s;
      case (state_r)
        ST_IDLE:  state_r <= pop_s ? ST_APPLY : ST_IDLE;
        ST_APPLY: state_r <= ST_RESP;
        ST_RESP:  state_r <= wb_ack ? (pop_s ? ST_APPLY : ST_IDLE) : ST_RESP;
        default:  state_r <= ST_IDLE;
      endcase
    end
  end

  // Registered config strobe and completion, both launched as APPLY ends
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_we    <= 1'b0;
      cfg_type  <= 3'd0;
      cfg_rca   <= {RCA_W{1'b0}};
      cfg_index <= 7'd0;
      cfg_data  <= 8'd0;
      wb_valid  <= 1'b0;
      wb_id     <= {ID_W{1'b0}};
      wb_err    <= 1'b0;
    end else begin
      cfg_we <= 1'b0;
      if (state_r == ST_APPLY) begin
        cfg_we    <= !err_s;
        cfg_type  <= inst_r.f3;
        cfg_rca   <= inst_r.f7[RCA_W-1:0];
        cfg_index <= index_s;
        cfg_data  <= data_s;
        wb_valid  <= 1'b1;
        wb_id     <= inst_r.id;
        wb_err    <= err_s;
      end else if ((state_r == ST_RESP) && wb_ack) begin
        wb_valid <= 1'b0;
      end else begin
        wb_valid <= wb_valid;
      end
    end
  end

endmodule

// File: tb/tb_rca_cfg_decoder.sv
// Scoreboard bench for rca_cfg_decoder: directed config instructions with
// hand-computed expected completions, checked by an independent monitor.
module tb_rca_cfg_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [2:0]  issue_funct3 = 3'd0;
  logic [6:0]  issue_funct7 = 7'd0;
  logic [31:0] issue_rs1 = 32'd0;
  logic [31:0] issue_rs2 = 32'd0;
  logic [2:0]  issue_id = 3'd0;
  logic        cfg_we;
  logic [2:0]  cfg_type;
  logic [1:0]  cfg_rca;
  logic [6:0]  cfg_index;
  logic [7:0]  cfg_data;
  logic        wb_valid;
  logic        wb_ack = 1'b0;
  logic [2:0]  wb_id;
  logic        wb_err;
  logic        cfg_pending;

  rca_cfg_decoder dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_funct3(issue_funct3), .issue_funct7(issue_funct7), .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2), .issue_id(issue_id), .cfg_we(cfg_we), .cfg_type(cfg_type),
    .cfg_rca(cfg_rca), .cfg_index(cfg_index), .cfg_data(cfg_data), .wb_valid(wb_valid),
    .wb_ack(wb_ack), .wb_id(wb_id), .wb_err(wb_err), .cfg_pending(cfg_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] id;
    logic       err;
    logic [2:0] f3;
    logic [1:0] rca;
    logic       chk_rca;
    logic [6:0] idx;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   n_pushed = 0;
  int   n_flushed = 0;
  int   n_done = 0;
  logic prev_wbv = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: a new completion is the rising edge of wb_valid
  always @(negedge clk) begin
    if (rst) begin
      n_flushed = n_flushed + exp_q.size();
      exp_q.delete();
      prev_wbv <= 1'b0;
    end else begin
      if (wb_valid && !prev_wbv) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_completion", 32'(wb_id), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          n_done++;
          chk("wb_id", 32'(wb_id), 32'(e.id));
          chk("wb_err", 32'(wb_err), 32'(e.err));
          chk("cfg_we", 32'(cfg_we), 32'(!e.err));
          if (!e.err) begin
            chk("cfg_type", 32'(cfg_type), 32'(e.f3));
            chk("cfg_index", 32'(cfg_index), 32'(e.idx));
            chk("cfg_data", 32'(cfg_data), 32'(e.data));
            if (e.chk_rca) chk("cfg_rca", 32'(cfg_rca), 32'(e.rca));
          end
        end
      end else if (cfg_we) begin
        chk("orphan_cfg_we", 32'(cfg_we), 32'd0);
      end
      prev_wbv <= wb_valid;
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] rs1,
                      input logic [31:0] rs2, input logic [2:0] id, input logic err,
                      input logic [6:0] idx, input logic [7:0] data);
    exp_t e;
    int n;
    n = 0;
    while (!issue_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("issue_ready_timeout", 32'(issue_ready), 32'd1);
    e.id = id; e.err = err; e.f3 = f3; e.rca = f7[1:0]; e.idx = idx; e.data = data;
    e.chk_rca = (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b101);
    issue_funct3 = f3; issue_funct7 = f7; issue_rs1 = rs1; issue_rs2 = rs2; issue_id = id;
    issue_valid = 1'b1;
    exp_q.push_back(e);
    n_pushed++;
    @(posedge clk);
    #1 issue_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    wb_ack = 1'b1;
    while ((cfg_pending || wb_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(cfg_pending || wb_valid), 32'd0);
    wb_ack = 1'b0;
  endtask

  int we_cyc[8];
  int nwe;
  int low_cyc;
  int bad;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_issue_ready", 32'(issue_ready), 32'd1);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_cfg_we", 32'(cfg_we), 32'd0);
    chk("rst_pending", 32'(cfg_pending), 32'd0);
    chk("rst_cfg_index", 32'(cfg_index), 32'd0);

    // Latency and hold of a single grid-mux write
    push(3'b010, 7'd0, 32'd71, 32'd5, 3'd2, 1'b0, 7'd71, 8'd5);
    chk("lat_pending", 32'(cfg_pending), 32'd1);
    chk("lat_we_n1", 32'(cfg_we), 32'd0);
    @(negedge clk);
    chk("lat_we_apply", 32'(cfg_we), 32'd0);
    @(negedge clk);
    chk("lat_we_n2", 32'(cfg_we), 32'd1);
    chk("lat_wbv_n2", 32'(wb_valid), 32'd1);
    repeat (3) @(negedge clk);
    chk("hold_we_low", 32'(cfg_we), 32'd0);
    chk("hold_wbv", 32'(wb_valid), 32'd1);
    chk("hold_id", 32'(wb_id), 32'd2);
    wb_ack = 1'b1;
    @(negedge clk);
    wb_ack = 1'b0;
    chk("ack_wbv_low", 32'(wb_valid), 32'd0);
    @(negedge clk);

    // Legal and out-of-range vectors
    wb_ack = 1'b1;
    push(3'b010, 7'd0, 32'd72, 32'd0, 3'd3, 1'b1, 7'd0, 8'd0);
    push(3'b100, 7'd4, 32'd0, 32'd0, 3'd4, 1'b1, 7'd0, 8'd0);
    push(3'b001, 7'd3, 32'h1A, 32'd17, 3'd5, 1'b0, 7'h1A, 8'd17);
    push(3'b011, 7'd0, 32'd5, 32'd10, 3'd6, 1'b0, 7'd5, 8'd10);
    push(3'b011, 7'd0, 32'd0, 32'd11, 3'd7, 1'b1, 7'd0, 8'd0);
    push(3'b100, 7'd2, 32'd4, 32'd5, 3'd0, 1'b0, 7'd4, 8'd5);
    push(3'b101, 7'd1, 32'h15, 32'd0, 3'd1, 1'b0, 7'd0, 8'h15);
    push(3'b000, 7'd0, 32'd0, 32'd0, 3'd2, 1'b1, 7'd0, 8'd0);
    push(3'b111, 7'd0, 32'd0, 32'd0, 3'd3, 1'b1, 7'd0, 8'd0);
    push(3'b010, 7'd0, 32'h8000_0001, 32'd1, 3'd4, 1'b1, 7'd0, 8'd0);
    push(3'b001, 7'd0, 32'h05, 32'd1, 3'd5, 1'b1, 7'd0, 8'd0);
    push(3'b010, 7'd0, 32'd0, 32'd8, 3'd6, 1'b1, 7'd0, 8'd0);
    drain();

    // Backpressure with completions held off
    push(3'b010, 7'd0, 32'd1, 32'd1, 3'd1, 1'b0, 7'd1, 8'd1);
    push(3'b010, 7'd0, 32'd2, 32'd2, 3'd2, 1'b0, 7'd2, 8'd2);
    push(3'b010, 7'd0, 32'd3, 32'd3, 3'd3, 1'b0, 7'd3, 8'd3);
    chk("full_ready_low", 32'(issue_ready), 32'd0);
    repeat (3) @(negedge clk);
    chk("full_ready_held", 32'(issue_ready), 32'd0);
    chk("full_wb_id", 32'(wb_id), 32'd1);
    wb_ack = 1'b1;
    push(3'b010, 7'd0, 32'd4, 32'd4, 3'd4, 1'b0, 7'd4, 8'd4);
    drain();

    // Streaming with wb_ack held high
    wb_ack = 1'b1;
    nwe = 0;
    low_cyc = -1;
    fork
      begin
        for (int i = 0; i < 4; i++)
          push(3'b011, 7'd0, 32'(i), 32'(i + 1), 3'(i), 1'b0, 7'(i), 8'(i + 1));
      end
      begin
        for (int k = 0; k < 60; k++) begin
          @(negedge clk);
          if (cfg_we && nwe < 8) begin
            we_cyc[nwe] = cyc;
            nwe++;
          end
          if (nwe == 4 && !cfg_pending && low_cyc < 0) low_cyc = cyc;
        end
      end
    join
    chk("stream_we_count", 32'(nwe), 32'd4);
    for (int i = 1; i < 4; i++) chk("stream_we_spacing", 32'(we_cyc[i] - we_cyc[i-1]), 32'd2);
    chk("stream_pending_low", 32'(low_cyc), 32'(we_cyc[3] + 1));
    wb_ack = 1'b0;

    // Reset while applying with more instructions buffered
    push(3'b010, 7'd0, 32'd5, 32'd5, 3'd5, 1'b0, 7'd5, 8'd5);
    push(3'b010, 7'd0, 32'd6, 32'd6, 3'd6, 1'b0, 7'd6, 8'd6);
    push(3'b010, 7'd0, 32'd7, 32'd7, 3'd7, 1'b0, 7'd7, 8'd7);
    wb_ack = 1'b1;
    @(negedge clk);
    wb_ack = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (cfg_we || wb_valid) bad++;
    end
    chk("post_rst_quiet", 32'(bad), 32'd0);
    chk("post_rst_ready", 32'(issue_ready), 32'd1);
    chk("post_rst_pending", 32'(cfg_pending), 32'd0);
    chk("completions", 32'(n_done), 32'(n_pushed - n_flushed));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
